compute_request_arbiter: RTL
============================

Name: compute_request_arbiter

Overview:
- Initiator side of the shared compute unit protocol (unit_id / request / ready / done / comp_type / operands / result).
- Collects operation requests from up to NUM_UNITS client units and grants the shared compute unit to one of them in round-robin order.
- Drives the grant onto the compute unit's control and data inputs, waits for done, then returns the registered result to the granted client with a one-cycle response pulse.
- Adds a done-timeout so that a hung compute unit cannot lock out every client.

Parameters:
- NUM_UNITS, 4, number of client units; unit id width is 2 bits, so NUM_UNITS must be 4 or less.
- VECTOR_DEPTH, 16, elements per operand or result vector.
- ELEM_WIDTH, 32, bits per vector element.
- TIMEOUT_CYCLES, 64, cycles spent in WAIT without done before the transaction is aborted.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- unit_req_valid  in  NUM_UNITS  per-unit request; held high until that unit's resp_valid pulse.
- unit_comp_type  in  NUM_UNITS*2  per-unit computation type (2-bit encoding from accel_pkg).
- unit_vector_a  in  NUM_UNITS*VECTOR_DEPTH*ELEM_WIDTH  per-unit operand A.
- unit_vector_b  in  NUM_UNITS*VECTOR_DEPTH*ELEM_WIDTH  per-unit operand B.
- unit_matrix  in  NUM_UNITS*VECTOR_DEPTH*VECTOR_DEPTH*2  per-unit ternary matrix; each element is {sign, enable}.
- resp_valid  out  NUM_UNITS  one-hot, one-cycle completion pulse.
- resp_error  out  1  high together with resp_valid when the transaction timed out.
- resp_result  out  VECTOR_DEPTH*ELEM_WIDTH  registered result; valid while resp_valid is high.
- busy  out  1  high in every state except IDLE.
- cu_unit_id  out  2  granted unit id.
- cu_request  out  1  request to the compute unit.
- cu_ready  in  1  compute unit can accept a request.
- cu_done  in  1  compute unit finished.
- cu_comp_type  out  2  granted unit's computation type.
- cu_vector_a  out  VECTOR_DEPTH*ELEM_WIDTH  granted unit's operand A.
- cu_vector_b  out  VECTOR_DEPTH*ELEM_WIDTH  granted unit's operand B.
- cu_matrix  out  VECTOR_DEPTH*VECTOR_DEPTH*2  granted unit's matrix.
- cu_result  in  VECTOR_DEPTH*ELEM_WIDTH  compute unit result.

Behaviour:
- Reset values: state=IDLE, grant=0, rr_ptr=0 (unit 0 has highest priority), cu_request=0, resp_valid=0, resp_error=0, resp_result=0, timeout counter=0, busy=0.
- Reset mid-operation returns immediately to these values; the in-flight transaction is dropped and no response is issued.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If any unit_req_valid is high, register grant = first requesting index searching rr_ptr, rr_ptr+1, ... mod NUM_UNITS, then go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - cu_request=1 and cu_unit_id=grant, both registered, so the first request cycle is one cycle after the IDLE decision.
  - Accepted at a clock edge where cu_ready=1; go to WAIT with cu_request=0 in the next cycle.
  - cu_done while in REQ is ignored.
- WAIT:
  - Timeout counter clears on entry and increments each cycle.
  - cu_done=1: capture cu_result into resp_result, resp_error=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without done: resp_result=0, resp_error=1, go to RESP.
  - If done arrives on the same edge as the timeout, done wins.
- RESP:
  - resp_valid[grant]=1 for exactly one cycle.
  - rr_ptr=(grant+1) mod NUM_UNITS, then go to IDLE.
  - A request still held in the RESP cycle is ignored; the next arbitration happens in IDLE.
- Operand muxing is combinational from the registered grant: cu_comp_type, cu_vector_a, cu_vector_b and cu_matrix always show unit[grant]'s inputs. Clients keep their operands stable until resp_valid.
- Minimum transaction, done on the first WAIT cycle with ready already high: IDLE to resp_valid takes 4 cycles. A new grant can follow 1 cycle after RESP.
- Dropping unit_req_valid after the grant has no effect; the transaction completes and the response pulse is still issued.
- Requests from indices at or above NUM_UNITS do not exist. resp_result holds its value after RESP until the next capture.

Test Plan:
- Single request: unit 2 requests with comp_type=1 and a[i]=i, b[i]=2i; model returns a+b.
  - Required: cu_unit_id=2 with cu_request high until ready.
  - Required: resp_valid=4'b0100 for 1 cycle, resp_result[i]=3i, resp_error=0.
- Round-robin: all 4 units request continuously from reset. Required: grant order 0,1,2,3,0 and each unit receives exactly one resp_valid per round.
- Ready stall: cu_ready held low for 10 cycles while unit 1 requests.
  - Required: cu_request stays high for 11 cycles, then falls the cycle after acceptance.
  - Required: no done accepted before acceptance; a done pulse injected in REQ is ignored.
- Timeout: unit 3 is granted and cu_done never arrives. Required: exactly 64 WAIT cycles, then resp_valid=4'b1000, resp_error=1, resp_result=0, and the next request is served normally.
- Done/timeout collision: done asserted in the 64th WAIT cycle. Required: resp_error=0 and resp_result equals cu_result.
- Reset mid-WAIT: assert rst_n=0 while unit 0 is in WAIT. Required: all outputs are at reset values while reset is asserted, no resp_valid pulse, and after release unit 0 (still requesting) is granted first.

Source files
------------

// File: rtl/compute_request_arbiter_if.sv
// Control and data bus between the request arbiter (master) and the shared
// compute unit (slave).
interface compute_request_arbiter_if #(
  parameter int VECTOR_DEPTH = 16,
  parameter int ELEM_WIDTH   = 32
) ();
  localparam int VW = VECTOR_DEPTH * ELEM_WIDTH;
  localparam int MW = VECTOR_DEPTH * VECTOR_DEPTH * 2;

  logic [1:0]    cu_unit_id;
  logic          cu_request;
  logic          cu_ready;
  logic          cu_done;
  logic [1:0]    cu_comp_type;
  logic [VW-1:0] cu_vector_a;
  logic [VW-1:0] cu_vector_b;
  logic [MW-1:0] cu_matrix;
  logic [VW-1:0] cu_result;

  modport master (
    output cu_unit_id, cu_request, cu_comp_type, cu_vector_a, cu_vector_b, cu_matrix,
    input  cu_ready, cu_done, cu_result
  );

  modport slave (
    input  cu_unit_id, cu_request, cu_comp_type, cu_vector_a, cu_vector_b, cu_matrix,
    output cu_ready, cu_done, cu_result
  );
endinterface

// File: rtl/compute_request_arbiter.sv
// Round-robin arbiter granting the shared compute unit to one of NUM_UNITS
// clients, with a done-timeout so a hung compute unit cannot lock everyone out.
//   state  | meaning
//   S_IDLE | no transaction, arbitrate among pending requests
//   S_REQ  | cu_request high for the granted unit until cu_ready
//   S_WAIT | waiting for cu_done, timeout counter running
//   S_RESP | one-cycle resp_valid pulse to the granted unit
module compute_request_arbiter #(
  parameter int NUM_UNITS      = 4,
  parameter int VECTOR_DEPTH   = 16,
  parameter int ELEM_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int VW = VECTOR_DEPTH * ELEM_WIDTH,
  localparam int MW = VECTOR_DEPTH * VECTOR_DEPTH * 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_UNITS-1:0]   unit_req_valid_i,
  input  logic [NUM_UNITS*2-1:0] unit_comp_type_i,
  input  logic [NUM_UNITS*VW-1:0] unit_vector_a_i,
  input  logic [NUM_UNITS*VW-1:0] unit_vector_b_i,
  input  logic [NUM_UNITS*MW-1:0] unit_matrix_i,
  output logic [NUM_UNITS-1:0]   resp_valid_o,
  output logic                   resp_error_o,
  output logic [VW-1:0]          resp_result_o,
  output logic                   busy_o,
  compute_request_arbiter_if.master cu
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic          request_q, request_d;
  logic          resp_error_q, resp_error_d;
  logic [VW-1:0] resp_result_q, resp_result_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    arb_idx;
  logic          arb_found;
  int            cand;
  logic          tmo_hit;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // First requester at or after rr_ptr, wrapping around
  always_comb begin
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      cand = (int'(rr_ptr_q) + i) % NUM_UNITS;
      if (!arb_found && unit_req_valid_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = 2'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (|unit_req_valid_i)         state_d = S_REQ;
      S_REQ:   if (cu.cu_ready)               state_d = S_WAIT;
      S_WAIT:  if (cu.cu_done || tmo_hit)     state_d = S_RESP;
      S_RESP:                                 state_d = S_IDLE;
      default:                                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q != S_IDLE);
    resp_valid_o = '0;
    if (state_q == S_RESP) resp_valid_o[grant_q] = 1'b1;
  end

  always_comb begin
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    request_d     = request_q;
    resp_error_d  = resp_error_q;
    resp_result_d = resp_result_q;
    tmo_d         = tmo_q;
    case (state_q)
      S_IDLE: if (|unit_req_valid_i) begin
        grant_d   = arb_idx;
        request_d = 1'b1;
      end
      S_REQ: if (cu.cu_ready) begin
        request_d = 1'b0;
        tmo_d     = '0;
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // done takes priority over a timeout on the same edge
        if (cu.cu_done) begin
          resp_result_d = cu.cu_result;
          resp_error_d  = 1'b0;
        end else if (tmo_hit) begin
          resp_result_d = '0;
          resp_error_d  = 1'b1;
        end
      end
      S_RESP: rr_ptr_d = (grant_q == 2'(NUM_UNITS - 1)) ? 2'd0 : grant_q + 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      request_q     <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_result_q <= '0;
      tmo_q         <= '0;
    end else begin
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      request_q     <= request_d;
      resp_error_q  <= resp_error_d;
      resp_result_q <= resp_result_d;
      tmo_q         <= tmo_d;
    end
  end

  assign resp_error_o    = resp_error_q;
  assign resp_result_o   = resp_result_q;
  assign cu.cu_request   = request_q;
  assign cu.cu_unit_id   = grant_q;
  assign cu.cu_comp_type = unit_comp_type_i[int'(grant_q)*2 +: 2];
  assign cu.cu_vector_a  = unit_vector_a_i[int'(grant_q)*VW +: VW];
  assign cu.cu_vector_b  = unit_vector_b_i[int'(grant_q)*VW +: VW];
  assign cu.cu_matrix    = unit_matrix_i[int'(grant_q)*MW +: MW];
endmodule
